basic_io_n: RTL and testbench

BASIC_IO_N -- requirements
Module: basic_io_n

---
 rtl/basic_io_n_if.sv | 13 +
 rtl/basic_io_n.sv | 205 ++++++++++++++++++++
 tb/tb_basic_io_n.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/basic_io_n_if.sv
// Register bus between a host and the basic_io_n block: address, write data,
// write strobe and a combinational read-data return.
interface basic_io_n_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        we;

  // No handshake: a write commits on the rising edge where we is high, and
  // data_out follows addr combinationally.
  modport master (output addr, output data_in, output we, input data_out);
  modport slave  (input addr, input data_in, input we, output data_out);
endinterface

// File: rtl/basic_io_n.sv
// Memory-mapped board I/O: synchronized switches, debounced buttons with press
// latches, LED register and a multiplexed 7-segment display.
module basic_io_n #(
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter int          NUM_SW     = 16,
  parameter int          NUM_BTN    = 5,
  parameter int          NUM_LED    = 16,
  parameter int          NUM_DIGITS = 4,
  parameter int          SCAN_BITS  = 16,
  parameter int          DB_CYCLES  = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  basic_io_n_if.slave           bus,
  input  logic [NUM_SW-1:0]     sw,
  input  logic [NUM_BTN-1:0]    btn,
  output logic [NUM_LED-1:0]    led,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DB_W  = $clog2(DB_CYCLES);

  localparam logic [7:0] OFF_SW    = 8'h00;
  localparam logic [7:0] OFF_LEVEL = 8'h02;
  localparam logic [7:0] OFF_LATCH = 8'h04;
  localparam logic [7:0] OFF_LED   = 8'h10;
  localparam logic [7:0] OFF_DIGIT = 8'h20;
  localparam logic [7:0] OFF_CTRL  = 8'h30;
  localparam logic [7:0] OFF_MASK  = 8'h32;

  logic [NUM_SW-1:0]     sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [NUM_BTN-1:0]    btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
  logic [NUM_BTN-1:0]    btn_lvl_q, btn_lvl_d, btn_lvl_dly_q, btn_lvl_dly_d;
  logic [DB_W-1:0]       db_cnt_q [NUM_BTN];
  logic [DB_W-1:0]       db_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0]    latch_q, latch_d, latch_clr;
  logic [NUM_LED-1:0]    led_q, led_d;
  logic [7:0]            digit_q [NUM_DIGITS];
  logic [7:0]            digit_d [NUM_DIGITS];
  logic [1:0]            ctrl_q, ctrl_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [SCAN_BITS-1:0]  scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic                  page_hit;
  logic                  wr_en;
  logic [7:0]            off;
  logic [15:0]           rd_data;
  logic [7:0]            cur_digit;
  logic                  cur_mask;
  logic                  blank;
  logic [NUM_DIGITS-1:0] an_sel;

  // Segment order is {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] glyph(input logic [4:0] code);
    case (code)
      5'h00: glyph = 7'b1000000;
      5'h01: glyph = 7'b1111001;
      5'h02: glyph = 7'b0100100;
      5'h03: glyph = 7'b0110000;
      5'h04: glyph = 7'b0011001;
      5'h05: glyph = 7'b0010010;
      5'h06: glyph = 7'b0000010;
      5'h07: glyph = 7'b1111000;
      5'h08: glyph = 7'b0000000;
      5'h09: glyph = 7'b0010000;
      5'h0A: glyph = 7'b0001000;
      5'h0B: glyph = 7'b0000011;
      5'h0C: glyph = 7'b1000110;
      5'h0D: glyph = 7'b0100001;
      5'h0E: glyph = 7'b0000110;
      5'h0F: glyph = 7'b0001110;
      5'h11: glyph = 7'b0111111;
      5'h12: glyph = 7'b1100001;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  assign page_hit = (bus.addr[15:8] == BASE_ADDR[15:8]);
  assign off      = bus.addr[7:0];
  assign wr_en    = bus.we && page_hit;

  always_comb begin
    sw_meta_d     = sw;
    sw_sync_d     = sw_meta_q;
    btn_meta_d    = btn;
    btn_sync_d    = btn_meta_q;
    btn_lvl_d     = btn_lvl_q;
    btn_lvl_dly_d = btn_lvl_q;
    db_cnt_d      = db_cnt_q;
    led_d         = led_q;
    digit_d       = digit_q;
    ctrl_d        = ctrl_q;
    mask_d        = mask_q;

    // Level flips on the DB_CYCLES-th consecutive disagreeing cycle.
    for (int b = 0; b < NUM_BTN; b++) begin
      if (btn_sync_q[b] != btn_lvl_q[b]) begin
        if (db_cnt_q[b] == DB_W'(DB_CYCLES - 1)) begin
          btn_lvl_d[b] = ~btn_lvl_q[b];
          db_cnt_d[b]  = '0;
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 1'b1;
        end
      end else begin
        db_cnt_d[b] = '0;
      end
    end

    latch_clr = (wr_en && off == OFF_LATCH) ? bus.data_in[NUM_BTN-1:0] : '0;
    latch_d   = (latch_q & ~latch_clr) | (btn_lvl_q & ~btn_lvl_dly_q);

    if (wr_en && off == OFF_LED)  led_d  = bus.data_in[NUM_LED-1:0];
    if (wr_en && off == OFF_CTRL) ctrl_d = bus.data_in[1:0];
    if (wr_en && off == OFF_MASK) mask_d = bus.data_in[NUM_DIGITS-1:0];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (wr_en && off == OFF_DIGIT + 8'(i)) digit_d[i] = bus.data_in[7:0];
    end

    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (&scan_cnt_q) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    if (page_hit) begin
      if (off == OFF_SW)    rd_data[NUM_SW-1:0]     = sw_sync_q;
      if (off == OFF_LEVEL) rd_data[NUM_BTN-1:0]    = btn_lvl_q;
      if (off == OFF_LATCH) rd_data[NUM_BTN-1:0]    = latch_q;
      if (off == OFF_LED)   rd_data[NUM_LED-1:0]    = led_q;
      if (off == OFF_CTRL)  rd_data[1:0]            = ctrl_q;
      if (off == OFF_MASK)  rd_data[NUM_DIGITS-1:0] = mask_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (off == OFF_DIGIT + 8'(i)) rd_data[7:0] = digit_q[i];
      end
    end
  end

  assign bus.data_out = rd_data;
  assign led          = led_q;

  // Digit 0 is leftmost, so index i drives the mirrored anode bit.
  always_comb begin
    cur_digit = '0;
    cur_mask  = 1'b0;
    an_sel    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit                = digit_q[i];
        cur_mask                 = mask_q[i];
        an_sel[NUM_DIGITS-1-i]   = 1'b1;
      end
    end
    blank = ctrl_q[1] | ~cur_mask;
    an    = '1;
    seg   = '1;
    dp    = 1'b1;
    if (!blank) begin
      an  = ~an_sel;
      seg = ctrl_q[0] ? ~cur_digit[6:0] : glyph(cur_digit[4:0]);
      dp  = ~cur_digit[7];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
      btn_meta_q    <= '0;
      btn_sync_q    <= '0;
      btn_lvl_q     <= '0;
      btn_lvl_dly_q <= '0;
      latch_q       <= '0;
      led_q         <= '0;
      ctrl_q        <= '0;
      mask_q        <= '1;
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      for (int b = 0; b < NUM_BTN; b++) db_cnt_q[b] <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 8'h10;
    end else begin
      sw_meta_q     <= sw_meta_d;
      sw_sync_q     <= sw_sync_d;
      btn_meta_q    <= btn_meta_d;
      btn_sync_q    <= btn_sync_d;
      btn_lvl_q     <= btn_lvl_d;
      btn_lvl_dly_q <= btn_lvl_dly_d;
      latch_q       <= latch_d;
      led_q         <= led_d;
      ctrl_q        <= ctrl_d;
      mask_q        <= mask_d;
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      db_cnt_q      <= db_cnt_d;
      digit_q       <= digit_d;
    end
  end

endmodule

// File: tb/tb_basic_io_n.sv
// Self-checking bench for basic_io_n: register vectors, display scan and
// glyphs, button debounce/latch timing and reset behaviour.
module tb_basic_io_n;

  localparam logic [15:0] BASE = 16'h4000;

  logic clk = 1'b0;
  logic rst, rst3;
  always #5 clk = ~clk;

  basic_io_n_if bus();
  basic_io_n_if bus3();

  logic [15:0] sw, sw3;
  logic [4:0]  btn, btn3;
  logic [15:0] led, led3;
  logic [6:0]  seg, seg3;
  logic        dp, dp3;
  logic [3:0]  an;
  logic [2:0]  an3;

  basic_io_n #(.BASE_ADDR(BASE), .NUM_DIGITS(4), .SCAN_BITS(2), .DB_CYCLES(4)) u_dut (
    .clk(clk), .reset(rst), .bus(bus), .sw(sw), .btn(btn),
    .led(led), .seg(seg), .dp(dp), .an(an)
  );

  basic_io_n #(.NUM_DIGITS(3), .SCAN_BITS(2), .DB_CYCLES(2)) u_dut3 (
    .clk(clk), .reset(rst3), .bus(bus3), .sw(sw3), .btn(btn3),
    .led(led3), .seg(seg3), .dp(dp3), .an(an3)
  );

  int n_vec, n_err;
  logic [15:0] exp_q[$];

  // Scan position of u_dut: index advances every 4 cycles, 0..3.
  int m_cnt, m_idx;
  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0;
      m_idx <= 0;
    end else begin
      m_cnt <= (m_cnt + 1) % 4;
      if (m_cnt == 3) m_idx <= (m_idx + 1) % 4;
    end
  end

  typedef struct {
    logic        do_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [19];

  typedef struct {
    logic [7:0] val;
    logic [6:0] seg;
    logic       dp;
  } gly_t;
  gly_t glys [11];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.addr = a; bus.data_in = d; bus.we = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic rd_now(input string name, input logic [15:0] a, input logic [15:0] exp);
    bus.addr = a;
    exp_q.push_back(exp);
    #2;
    chk(name, bus.data_out, exp_q.pop_front());
  endtask

  task automatic wait_idx(input int i);
    int k;
    k = 0;
    while (m_idx != i && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (m_idx != i) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idx: index %0d never reached, got %0d", i, m_idx);
    end
  endtask

  task automatic chk_disp(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                          input logic e_dp);
    chk({name, "_an"}, {12'h0, an}, {12'h0, e_an});
    chk({name, "_seg"}, {9'h0, seg}, {9'h0, e_seg});
    chk({name, "_dp"}, {15'h0, dp}, {15'h0, e_dp});
  endtask

  function automatic logic [2:0] an3_exp(input int k);
    case ((k / 4) % 3)
      0: an3_exp = 3'b011;
      1: an3_exp = 3'b101;
      default: an3_exp = 3'b110;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; rst3 = 1'b1;
    bus.addr = '0; bus.data_in = '0; bus.we = 1'b0;
    bus3.addr = '0; bus3.data_in = '0; bus3.we = 1'b0;
    sw = 16'h3C5A; btn = '0; sw3 = '0; btn3 = '0;

    vecs[0]  = '{1'b0, 16'h4021, 16'h0000, 16'h0010};
    vecs[1]  = '{1'b0, 16'h4030, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 16'h4032, 16'h0000, 16'h000F};
    vecs[3]  = '{1'b0, 16'h4004, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b0, 16'h4000, 16'h0000, 16'h3C5A};
    vecs[5]  = '{1'b1, 16'h4000, 16'hFFFF, 16'h3C5A};
    vecs[6]  = '{1'b1, 16'h4010, 16'hA5A5, 16'hA5A5};
    vecs[7]  = '{1'b0, 16'h4012, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b1, 16'h4020, 16'h1183, 16'h0083};
    vecs[9]  = '{1'b1, 16'h4023, 16'hFF5A, 16'h005A};
    vecs[10] = '{1'b1, 16'h4024, 16'h1234, 16'h0000};
    vecs[11] = '{1'b1, 16'h4030, 16'hFFFF, 16'h0003};
    vecs[12] = '{1'b1, 16'h4030, 16'h0000, 16'h0000};
    vecs[13] = '{1'b1, 16'h4032, 16'hFFF5, 16'h0005};
    vecs[14] = '{1'b1, 16'h4032, 16'h000F, 16'h000F};
    vecs[15] = '{1'b1, 16'h5010, 16'h1234, 16'h0000};
    vecs[16] = '{1'b0, 16'h4010, 16'h0000, 16'hA5A5};
    vecs[17] = '{1'b0, 16'h4002, 16'h0000, 16'h0000};
    vecs[18] = '{1'b1, 16'h40FF, 16'h1234, 16'h0000};

    glys[0]  = '{8'h00, 7'b1000000, 1'b1};
    glys[1]  = '{8'h05, 7'b0010010, 1'b1};
    glys[2]  = '{8'h0A, 7'b0001000, 1'b1};
    glys[3]  = '{8'h0B, 7'b0000011, 1'b1};
    glys[4]  = '{8'h0F, 7'b0001110, 1'b1};
    glys[5]  = '{8'h10, 7'b1111111, 1'b1};
    glys[6]  = '{8'h11, 7'b0111111, 1'b1};
    glys[7]  = '{8'h12, 7'b1100001, 1'b1};
    glys[8]  = '{8'h1F, 7'b1111111, 1'b1};
    glys[9]  = '{8'h88, 7'b0000000, 1'b0};
    glys[10] = '{8'h6E, 7'b0000110, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state: digit 0 selected, blank glyph, LEDs off.
    chk_disp("reset", 4'b0111, 7'b1111111, 1'b1);
    chk("reset_led", led, 16'h0000);

    // Scan of the 3-digit instance, wrap 2->0, then reset mid-digit-1.
    rst3 = 1'b0;
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("scan3_k%0d", k), {13'h0, an3}, {13'h0, an3_exp(k)});
      @(negedge clk);
    end
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("scan3_rst_k%0d", k), {13'h0, an3}, {13'h0, an3_exp(k)});
      @(negedge clk);
    end

    // Register vectors.
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
      rd_now($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
      @(negedge clk);
    end
    chk("led_out", led, 16'hA5A5);

    // Switch synchronizer latency.
    sw = 16'h0FF0;
    @(negedge clk);
    rd_now("sw_lat1", 16'h4000, 16'h3C5A);
    @(negedge clk);
    rd_now("sw_lat2", 16'h4000, 16'h0FF0);

    // Display: pattern mode digit 0 = 0x83, then raw mode.
    wait_idx(0);
    chk_disp("pat_d0", 4'b0111, 7'b0110000, 1'b0);
    wr(16'h4030, 16'h0001);
    wr(16'h4021, 16'h007F);
    wait_idx(1);
    chk_disp("raw_d1", 4'b1011, 7'b0000000, 1'b1);
    wait_idx(0);
    chk_disp("raw_d0", 4'b0111, 7'b1111100, 1'b0);
    wr(16'h4030, 16'h0000);

    for (int g = 0; g < 11; g++) begin
      wr(16'h4022, {8'h00, glys[g].val});
      wait_idx(2);
      chk_disp($sformatf("glyph%0d", g), 4'b1101, glys[g].seg, glys[g].dp);
    end

    // Digit mask and blank-all.
    wr(16'h4032, 16'h0007);
    wait_idx(3);
    chk_disp("mask7_d3", 4'b1111, 7'b1111111, 1'b1);
    wait_idx(0);
    chk_disp("mask7_d0", 4'b0111, 7'b0110000, 1'b0);
    wr(16'h4032, 16'h000E);
    wait_idx(0);
    chk_disp("maskE_d0", 4'b1111, 7'b1111111, 1'b1);
    wr(16'h4032, 16'h000F);
    wr(16'h4030, 16'h0002);
    for (int i = 0; i < 4; i++) begin
      wait_idx(i);
      chk_disp($sformatf("blank_d%0d", i), 4'b1111, 7'b1111111, 1'b1);
    end
    wr(16'h4030, 16'h0000);

    // Debounce: 3-cycle pulse is rejected.
    btn = 5'b00100;
    repeat (3) @(negedge clk);
    btn = '0;
    repeat (10) @(negedge clk);
    rd_now("short_lvl", 16'h4002, 16'h0000);
    rd_now("short_latch", 16'h4004, 16'h0000);

    // 6-cycle pulse sets the latch; level falls back afterwards.
    btn = 5'b00100;
    repeat (6) @(negedge clk);
    btn = '0;
    repeat (12) @(negedge clk);
    rd_now("pulse6_lvl", 16'h4002, 16'h0000);
    rd_now("pulse6_latch", 16'h4004, 16'h0004);
    wr(16'h4004, 16'h0004);
    rd_now("pulse6_clr", 16'h4004, 16'h0000);

    // Held button: exact toggle cycle, latch one cycle later, W1C.
    @(negedge clk);
    btn = 5'b00100;
    repeat (5) @(negedge clk);
    rd_now("hold_lvl5", 16'h4002, 16'h0000);
    @(negedge clk);
    rd_now("hold_lvl6", 16'h4002, 16'h0004);
    rd_now("hold_latch6", 16'h4004, 16'h0000);
    @(negedge clk);
    rd_now("hold_latch7", 16'h4004, 16'h0004);
    wr(16'h4004, 16'hFFFB);
    rd_now("w1c_other", 16'h4004, 16'h0004);
    wr(16'h4004, 16'h0004);
    rd_now("w1c_clr", 16'h4004, 16'h0000);
    btn = '0;
    repeat (10) @(negedge clk);
    rd_now("release_lvl", 16'h4002, 16'h0000);
    rd_now("release_latch", 16'h4004, 16'h0000);

    // Set wins over a clear in the same cycle (latch sets on edge 7).
    btn = 5'b00001;
    repeat (6) @(negedge clk);
    wr(16'h4004, 16'h0001);
    rd_now("set_wins", 16'h4004, 16'h0001);
    wr(16'h4004, 16'h0001);
    rd_now("set_wins_clr", 16'h4004, 16'h0000);
    btn = '0;
    repeat (10) @(negedge clk);

    // Reset overrides a concurrent write.
    wr(16'h4010, 16'h1234);
    chk("led_pre_rst", led, 16'h1234);
    bus.addr = 16'h4010; bus.data_in = 16'hFFFF; bus.we = 1'b1; rst = 1'b1;
    @(negedge clk);
    bus.we = 1'b0; rst = 1'b0;
    chk("rst_vs_wr_led", led, 16'h0000);
    rd_now("rst_vs_wr_rd", 16'h4010, 16'h0000);
    rd_now("rst_mask", 16'h4032, 16'h000F);

    // Reset mid-debounce restarts synchronizers and count.
    btn = 5'b00100;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rd_now("rst_db_lvl5", 16'h4002, 16'h0000);
    @(negedge clk);
    rd_now("rst_db_lvl6", 16'h4002, 16'h0004);
    btn = '0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
